// File: rtl/rvfi_pkg.sv
// Shared RVFI retirement record and helpers for the commit serializer.
// Lane records are sanitised on entry; halt is detected on the emitted record.
package rvfi_pkg;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        load_regfile;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_word_t;

  localparam logic [31:0] HALT_INST = 32'h0000006f;

  // x0 never holds a value, so a write to it must not look like one
  function automatic rvfi_word_t sanitize_word(input rvfi_word_t w);
    rvfi_word_t r;
    r = w;
    if (w.rd_addr == 5'd0) begin
      r.rd_wdata     = 32'h0000_0000;
      r.load_regfile = 1'b0;
    end else begin
      r.rd_wdata     = w.rd_wdata;
      r.load_regfile = w.load_regfile;
    end
    return r;
  endfunction

  function automatic logic is_halt(input rvfi_word_t w);
    return (w.inst == HALT_INST) && (w.pc_rdata == w.pc_wdata);
  endfunction

endpackage

// File: rtl/rvfi_compact_fifo.sv
// Multi-write, single-read circular buffer; valid lanes are packed into
// consecutive slots in ascending lane order.
module rvfi_compact_fifo
  import rvfi_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_en,
  input  logic [LANES-1:0]           push_valid,
  input  rvfi_word_t [LANES-1:0]     push_word,
  input  logic                       pop_en,
  output rvfi_word_t                 head_word,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE_C = (PW+1)'(1);

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  rvfi_word_t    mem_r [DEPTH];
  logic [PW-1:0] lane_slot_s [LANES];
  logic [PW:0]   push_cnt_s;
  logic          pop_s;

  // Each valid lane lands just after all lower-numbered valid lanes
  always_comb begin
    push_cnt_s = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_slot_s[i] = wr_ptr_r + push_cnt_s[PW-1:0];
      if (push_en && push_valid[i]) begin
        push_cnt_s = push_cnt_s + ONE_C;
      end else begin
        push_cnt_s = push_cnt_s;
      end
    end
    pop_s = pop_en && (count_r != '0);
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_r + push_cnt_s[PW-1:0];
      rd_ptr_r <= rd_ptr_r + PW'(pop_s);
      count_r  <= count_r + push_cnt_s - (PW+1)'(pop_s);
    end
  end

  // Storage is not reset: only slots between the pointers are ever read
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_en && push_valid[i]) begin
        mem_r[lane_slot_s[i]] <= push_word[i];
      end
    end
  end

  assign head_word = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/rvfi_commit_serializer.sv
// Serialises multi-wide ROB retirement into a single-commit RVFI stream with
// order numbering, x0 sanitising, halt detection and overflow flagging.
module rvfi_commit_serializer
  import rvfi_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int ORDER_W      = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COMMIT_WIDTH-1:0]       commit_valid,
  input  rvfi_word_t [COMMIT_WIDTH-1:0] commit_word,
  output logic                          commit_ready,
  output logic                          rvfi_commit,
  output logic [ORDER_W-1:0]            rvfi_order,
  output rvfi_word_t                    rvfi_word,
  output logic                          rvfi_halt,
  output logic                          overflow_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(COMMIT_WIDTH);

  logic [CNT_W-1:0]              count_s;
  rvfi_word_t                    head_s;
  rvfi_word_t [COMMIT_WIDTH-1:0] clean_word_s;
  logic                          ready_s;
  logic                          push_en_s;
  logic                          pop_s;
  logic                          any_valid_s;

  logic [ORDER_W-1:0] order_cnt_r;
  logic               rvfi_commit_r;
  logic [ORDER_W-1:0] rvfi_order_r;
  rvfi_word_t         rvfi_word_r;
  logic               halt_r;
  logic               err_r;

  // Ready depends only on registered occupancy; a halted tracer drops pushes
  always_comb begin
    any_valid_s = |commit_valid;
    ready_s     = (DEPTH_C - count_s) >= WIDTH_C;
    push_en_s   = ready_s && !halt_r;
    pop_s       = (count_s != '0) && !halt_r;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      clean_word_s[i] = sanitize_word(commit_word[i]);
    end
  end

  rvfi_compact_fifo #(
    .LANES (COMMIT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_en    (push_en_s),
    .push_valid (commit_valid),
    .push_word  (clean_word_s),
    .pop_en     (pop_s),
    .head_word  (head_s),
    .count      (count_s)
  );

  // Registered RVFI outputs, order counter and sticky halt/error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      order_cnt_r   <= '0;
      rvfi_commit_r <= 1'b0;
      rvfi_order_r  <= '0;
      rvfi_word_r   <= '0;
      halt_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      rvfi_commit_r <= pop_s;
      if (pop_s) begin
        rvfi_word_r  <= head_s;
        rvfi_order_r <= order_cnt_r;
        order_cnt_r  <= order_cnt_r + ORDER_W'(1);
        if (is_halt(head_s)) begin
          halt_r <= 1'b1;
        end
      end
      if (!halt_r && !ready_s && any_valid_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign commit_ready = ready_s;
  assign rvfi_commit  = rvfi_commit_r;
  assign rvfi_order   = rvfi_order_r;
  assign rvfi_word    = rvfi_word_r;
  assign rvfi_halt    = halt_r;
  assign overflow_err = err_r;

endmodule

// File: doc/rvfi_commit_serializer.md
# rvfi_commit_serializer

Parametrised retirement tracer between the ROB commit stage and the RVFI monitor. Accepts up to COMMIT_WIDTH retired-instruction words per cycle, compacts and buffers them in program order, and emits exactly one RVFI commit per cycle with a monotonically increasing order number. This supersedes the single-commit, combinational RVFI tap wired in the testbench top, adding multi-wide retire, buffering, backpressure, x0 sanitising and halt detection.

## Interface
Parameters:
- COMMIT_WIDTH, 2, max instructions retired by the ROB per cycle (1..4)
- DEPTH, 8, buffer entries; power of two, >= 2*COMMIT_WIDTH
- ORDER_W, 64, width of rvfi_order

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- commit_valid  in  COMMIT_WIDTH  per-lane retire valid; lane 0 is oldest
- commit_word  in  COMMIT_WIDTH x rvfi_word_t  per-lane retire record (inst, pc_rdata, pc_wdata, rs1/rs2 addr+rdata, rd_addr, rd_wdata, load_regfile, mem addr/rmask/wmask/rdata/wdata)
- commit_ready  out  1  buffer can take a full COMMIT_WIDTH group this cycle
- rvfi_commit  out  1  one retired instruction presented this cycle
- rvfi_order  out  ORDER_W  order number of presented instruction
- rvfi_word  out  rvfi_word_t  presented record
- rvfi_halt  out  1  halt loop retired (sticky)
- overflow_err  out  1  sticky: valid lanes presented while commit_ready low

## Operation
- Push: when commit_ready=1, all lanes with commit_valid=1 are written in ascending lane order into consecutive entries; gaps (e.g. valid=2'b10) are compacted. Number pushed = popcount(commit_valid).
- commit_ready = (DEPTH - count) >= COMMIT_WIDTH, combinational from registered count only (no path from commit_valid).
- commit_valid≠0 while commit_ready=0: nothing written, overflow_err set until reset.
- Pop: each cycle the buffer is non-empty and not halted, head entry is registered to outputs, rvfi_commit=1, rvfi_order=order_cnt, order_cnt++.
- Sanitise on push: if rd_addr==0, stored rd_wdata=0 and load_regfile=0.
- Halt: an emitted entry with inst==32'h0000006f and pc_rdata==pc_wdata raises rvfi_halt in the same cycle as its rvfi_commit; afterwards no further pops, pushes are ignored (commit_ready stays as computed, no error).
- Simultaneous push and pop: count_next = count + pushed - popped; a group pushed into an empty buffer is not bypassed.
- Pointers wrap modulo DEPTH; full is count==DEPTH, empty is count==0.

## Timing
- Reset values: commit_ready=1, rvfi_commit=0, rvfi_order=0, rvfi_word=0, rvfi_halt=0, overflow_err=0; count, pointers, order_cnt = 0.
- Latency: word pushed at edge t is presented at edge t+1 at earliest (buffer previously empty).
- Throughput: 1 emitted commit/cycle; sustained COMMIT_WIDTH-wide retire fills the buffer and deasserts commit_ready.
- Outputs all registered; rvfi_commit held for exactly one cycle per instruction.
- rst asserted mid-operation: buffer contents discarded, all outputs to reset values on the next edge; order restarts at 0.

## Structure
- rvfi_pkg: rvfi_word_t packed struct, HALT_INST constant (32'h0000006f).
- One sub-module: rvfi_compact_fifo (multi-write, single-read circular buffer with lane compaction); top holds order counter, sanitiser, halt and error logic.

## Test plan
- Single lane: valid=2'b01, pc_rdata=0x60 -> next cycle rvfi_commit=1, rvfi_order=0, pc_rdata=0x60.
- Dual retire x3 cycles (6 instr, pcs 0x0..0x14) -> six consecutive commits, orders 0..5, pcs in order; commit_ready low once count reaches 7.
- Gapped valid=2'b10 with lane1 pc=0x80 -> emitted as one commit, pc 0x80, no empty slot.
- rd_addr=0, rd_wdata=0xDEAD -> emitted rd_wdata=0, load_regfile=0.
- Fill to DEPTH, then valid=2'b11 with commit_ready=0 -> overflow_err=1, count unchanged, no data lost/duplicated.
- Retire inst=0x0000006f at pc 0x100 followed by more -> rvfi_halt=1 with its commit, no further commits; rst clears all.
